cci_mpf_csr_hub: RTL and testbench

Parametrised MMIO CSR hub for MPF shims. It claims one contiguous MMIO window and splits it into N_SHIMS equal sub-windows. Each sub-window holds a device-feature header (DFH) in a linked list, GUID, one RW control register and one RO status register. It generalises the fixed per-shim CSR layout and the VTP mode register (enable + self-clearing invalidate) to N shims with configurable self-clearing bits and a pipelined read path.

---
 rtl/cci_mpf_csr_hub_pkg.sv | 44 ++++
 rtl/cci_mpf_csr_shim_ctrl.sv | 44 ++++
 rtl/cci_mpf_csr_hub.sv | 160 ++++++++++++++++
 tb/tb_cci_mpf_csr_hub.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_csr_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_hub_pkg
// Purpose  : Shared definitions for the MPF CSR hub. Provides the per-shim
//            register offsets, the device-feature-header layout and a helper
//            that builds one DFH word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cci_mpf_csr_hub_pkg;

  // Byte offsets inside one shim sub-window
  localparam logic [31:0] CCI_MPF_HUB_DFH    = 32'h00;
  localparam logic [31:0] CCI_MPF_HUB_GUID_L = 32'h08;
  localparam logic [31:0] CCI_MPF_HUB_GUID_H = 32'h10;
  localparam logic [31:0] CCI_MPF_HUB_CTRL   = 32'h18;
  localparam logic [31:0] CCI_MPF_HUB_STATUS = 32'h20;

  // Feature type reported by every shim: basic building block
  localparam logic [3:0] CCI_MPF_DFH_TYPE_BBB = 4'h2;

  typedef struct packed {
    logic [3:0]  dfh_type;
    logic [18:0] rsvd_hi;
    logic        eol;
    logic [23:0] next;
    logic [3:0]  rsvd_lo;
    logic [11:0] id;
  } t_cci_mpf_dfh;

  function automatic t_cci_mpf_dfh cci_mpf_dfh_make(input logic        eol,
                                                    input logic [23:0] next,
                                                    input logic [11:0] id);
    t_cci_mpf_dfh d;
    d          = '0;
    d.dfh_type = CCI_MPF_DFH_TYPE_BBB;
    d.eol      = eol;
    d.next     = next;
    d.id       = id;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cci_mpf_csr_shim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_shim_ctrl
// Purpose  : One shim CTRL register. Written bits appear on ctrl for the
//            cycle after the write; bits in SELF_CLEAR then drop back to 0.
//            Readback always hides the self-clearing bits.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            wr_en, wr_data  - write strobe and data
//            ctrl            - live register value
//            wr_pulse        - high for the cycle following a write
//            rd_data         - readback value (self-clearing bits masked)
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_csr_shim_ctrl #(
  parameter logic [63:0] RESET_VAL  = 64'h0,
  parameter logic [63:0] SELF_CLEAR = 64'h2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  output logic [63:0] ctrl,
  output logic        wr_pulse,
  output logic [63:0] rd_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= RESET_VAL & ~SELF_CLEAR;
      wr_pulse <= 1'b0;
    end else if (wr_en) begin
      ctrl     <= wr_data;
      wr_pulse <= 1'b1;
    end else begin
      // Self-clearing bits live for exactly one cycle after a write
      ctrl     <= ctrl & ~SELF_CLEAR;
      wr_pulse <= 1'b0;
    end
  end

  assign rd_data = ctrl & ~SELF_CLEAR;

endmodule
`default_nettype wire

// File: rtl/cci_mpf_csr_hub.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_hub
// Purpose  : MMIO CSR hub for MPF shims. Claims one window split into
//            N_SHIMS equal sub-windows, each holding DFH, GUID, a RW CTRL
//            and a RO STATUS register. Reads have a fixed 2-cycle latency.
// Ports    : clk, reset                      - clock, sync active-high reset
//            mmio_rd_valid/addr/tid          - read request (word address)
//            mmio_wr_valid/addr/data         - write request (word address)
//            rd_rsp_valid/tid/data           - read response
//            ctrl_out, ctrl_wr_pulse         - per-shim CTRL and write strobe
//            status_in                       - per-shim status for STATUS
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_csr_hub
  import cci_mpf_csr_hub_pkg::*;
#(
  parameter int unsigned             N_SHIMS         = 6,
  parameter logic [31:0]             MMIO_BASE_ADDR  = 32'h0,
  parameter int unsigned             WIN_LOG2        = 6,
  parameter logic [N_SHIMS*128-1:0]  SHIM_GUIDS      = '0,
  parameter logic [63:0]             CTRL_RESET_VAL  = 64'h0,
  parameter logic [63:0]             CTRL_SELF_CLEAR = 64'h2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mmio_rd_valid,
  input  logic [15:0]             mmio_rd_addr,
  input  logic [8:0]              mmio_rd_tid,
  input  logic                    mmio_wr_valid,
  input  logic [15:0]             mmio_wr_addr,
  input  logic [63:0]             mmio_wr_data,
  output logic                    rd_rsp_valid,
  output logic [8:0]              rd_rsp_tid,
  output logic [63:0]             rd_rsp_data,
  output logic [N_SHIMS*64-1:0]   ctrl_out,
  output logic [N_SHIMS-1:0]      ctrl_wr_pulse,
  input  logic [N_SHIMS*64-1:0]   status_in
);

  localparam int unsigned IDX_W      = (N_SHIMS > 1) ? $clog2(N_SHIMS) : 1;
  localparam logic [31:0] WIN_BYTES  = 32'h1 << WIN_LOG2;
  localparam logic [31:0] SPAN_BYTES = N_SHIMS * WIN_BYTES;

  // Address decode. Subtracting the base first lets a single unsigned
  // compare reject addresses both below and above the window.
  logic [31:0]         rd_rel, wr_rel;
  logic                rd_hit, wr_hit;
  logic [IDX_W-1:0]    rd_idx, wr_idx;
  logic [WIN_LOG2-1:0] rd_off, wr_off;

  always_comb begin
    rd_rel = {14'b0, mmio_rd_addr, 2'b00} - MMIO_BASE_ADDR;
    rd_hit = mmio_rd_valid && !mmio_rd_addr[0] && (rd_rel < SPAN_BYTES);
    rd_idx = IDX_W'(rd_rel >> WIN_LOG2);
    rd_off = rd_rel[WIN_LOG2-1:0];
    wr_rel = {14'b0, mmio_wr_addr, 2'b00} - MMIO_BASE_ADDR;
    wr_hit = mmio_wr_valid && !mmio_wr_addr[0] && (wr_rel < SPAN_BYTES);
    wr_idx = IDX_W'(wr_rel >> WIN_LOG2);
    wr_off = wr_rel[WIN_LOG2-1:0];
  end

  // Per-shim CTRL registers
  logic [N_SHIMS*64-1:0] ctrl_rd;

  generate
    for (genvar i = 0; i < N_SHIMS; i++) begin : g_shim
      cci_mpf_csr_shim_ctrl #(
        .RESET_VAL  (CTRL_RESET_VAL),
        .SELF_CLEAR (CTRL_SELF_CLEAR)
      ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_hit && (wr_idx == IDX_W'(i)) && (32'(wr_off) == CCI_MPF_HUB_CTRL)),
        .wr_data  (mmio_wr_data),
        .ctrl     (ctrl_out[64*i +: 64]),
        .wr_pulse (ctrl_wr_pulse[i]),
        .rd_data  (ctrl_rd[64*i +: 64])
      );
    end
  endgenerate

  // CTRL readback is captured in S1, before a same-cycle write lands,
  // so a simultaneous read sees the pre-write value.
  logic [63:0] rd_ctrl_sel;

  always_comb begin
    rd_ctrl_sel = '0;
    for (int i = 0; i < int'(N_SHIMS); i++) begin
      if (rd_idx == IDX_W'(i)) rd_ctrl_sel = ctrl_rd[64*i +: 64];
    end
  end

  // Stage 1
  logic                s1_valid;
  logic [8:0]          s1_tid;
  logic [IDX_W-1:0]    s1_idx;
  logic [WIN_LOG2-1:0] s1_off;
  logic [63:0]         s1_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tid   <= '0;
      s1_idx   <= '0;
      s1_off   <= '0;
      s1_ctrl  <= '0;
    end else begin
      s1_valid <= rd_hit;
      s1_tid   <= mmio_rd_tid;
      s1_idx   <= rd_idx;
      s1_off   <= rd_off;
      s1_ctrl  <= rd_ctrl_sel;
    end
  end

  // Stage 2 data mux; STATUS is taken live during the S1 cycle
  logic [127:0] sel_guid;
  logic [63:0]  sel_status;
  logic         is_last;
  t_cci_mpf_dfh dfh;
  logic [63:0]  s2_data;

  always_comb begin
    sel_guid   = '0;
    sel_status = '0;
    for (int i = 0; i < int'(N_SHIMS); i++) begin
      if (s1_idx == IDX_W'(i)) begin
        sel_guid   = SHIM_GUIDS[128*i +: 128];
        sel_status = status_in[64*i +: 64];
      end
    end
    is_last = (32'(s1_idx) == N_SHIMS - 1);
    dfh     = cci_mpf_dfh_make(is_last, is_last ? 24'h0 : 24'(WIN_BYTES), 12'(s1_idx));
    s2_data = '0;
    case (32'(s1_off))
      CCI_MPF_HUB_DFH:    s2_data = dfh;
      CCI_MPF_HUB_GUID_L: s2_data = sel_guid[63:0];
      CCI_MPF_HUB_GUID_H: s2_data = sel_guid[127:64];
      CCI_MPF_HUB_CTRL:   s2_data = s1_ctrl;
      CCI_MPF_HUB_STATUS: s2_data = sel_status;
      default:            s2_data = '0;
    endcase
  end

  // Stage 2 response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= s1_valid;
      rd_rsp_tid   <= s1_tid;
      rd_rsp_data  <= s2_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_csr_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_csr_hub
// Purpose  : Self-checking bench for cci_mpf_csr_hub (3 shims, base 0x1000,
//            64-byte sub-windows). A behavioural model predicts responses
//            and CTRL outputs every cycle; directed scenarios pin literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_csr_hub;

  localparam int          N    = 3;
  localparam int          BASE = 'h1000;
  localparam int          WIN  = 64;
  localparam logic [63:0] RST  = 64'h0000_0000_0000_00A7;
  localparam logic [63:0] SC   = 64'h2;
  localparam logic [N*128-1:0] GUIDS = {
    128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
    128'h1111_2222_3333_4444_5555_6666_7777_8888,
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};

  logic              clk;
  logic              reset;
  logic              mmio_rd_valid;
  logic [15:0]       mmio_rd_addr;
  logic [8:0]        mmio_rd_tid;
  logic              mmio_wr_valid;
  logic [15:0]       mmio_wr_addr;
  logic [63:0]       mmio_wr_data;
  logic              rd_rsp_valid;
  logic [8:0]        rd_rsp_tid;
  logic [63:0]       rd_rsp_data;
  logic [N*64-1:0]   ctrl_out;
  logic [N-1:0]      ctrl_wr_pulse;
  logic [N*64-1:0]   status_in;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit rand_status = 0;
  logic [N*128-1:0] guids = GUIDS;

  cci_mpf_csr_hub #(
    .N_SHIMS         (N),
    .MMIO_BASE_ADDR  (32'h1000),
    .WIN_LOG2        (6),
    .SHIM_GUIDS      (GUIDS),
    .CTRL_RESET_VAL  (RST),
    .CTRL_SELF_CLEAR (SC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_rd_addr  (mmio_rd_addr),
    .mmio_rd_tid   (mmio_rd_tid),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_wr_addr  (mmio_wr_addr),
    .mmio_wr_data  (mmio_wr_data),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_tid    (rd_rsp_tid),
    .rd_rsp_data   (rd_rsp_data),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .status_in     (status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_hit(input logic [15:0] a);
    int b;
    b = int'(a) * 4;
    return (a[0] == 1'b0) && (b >= BASE) && (b < BASE + N * WIN);
  endfunction

  function automatic int m_shim(input logic [15:0] a);
    if (!m_hit(a)) return 0;
    return (int'(a) * 4 - BASE) / WIN;
  endfunction

  function automatic int m_off(input logic [15:0] a);
    if (!m_hit(a)) return 0;
    return (int'(a) * 4 - BASE) % WIN;
  endfunction

  function automatic logic [63:0] exp_read(input int s, input int off,
                                           input logic [63:0] snap,
                                           input logic [N*64-1:0] st);
    if (s < 0 || s >= N) return 64'h0;
    case (off)
      0:       return (64'h2 << 60) | ((s == N - 1) ? (64'h1 << 40) : (64'(WIN) << 16)) | 64'(s);
      8:       return guids[128*s +: 64];
      16:      return guids[128*s + 64 +: 64];
      24:      return snap & ~SC;
      32:      return st[64*s +: 64];
      default: return 64'h0;
    endcase
  endfunction

  logic [63:0] m_ctrl [N];
  logic [N-1:0] m_pulse;
  logic        m_p_valid;
  logic [8:0]  m_p_tid;
  int          m_p_shim;
  int          m_p_off;
  logic [63:0] m_p_snap;
  logic        m_rsp_valid;
  logic [8:0]  m_rsp_tid;
  logic [63:0] m_rsp_data;

  always @(posedge clk) begin
    if (reset) begin
      m_p_valid   <= 1'b0;
      m_rsp_valid <= 1'b0;
      m_rsp_tid   <= '0;
      m_rsp_data  <= '0;
      m_pulse     <= '0;
      for (int s = 0; s < N; s++) m_ctrl[s] <= RST & ~SC;
    end else begin
      m_rsp_valid <= m_p_valid;
      m_rsp_tid   <= m_p_tid;
      m_rsp_data  <= exp_read(m_p_shim, m_p_off, m_p_snap, status_in);
      m_p_valid   <= mmio_rd_valid && m_hit(mmio_rd_addr);
      m_p_tid     <= mmio_rd_tid;
      m_p_shim    <= m_shim(mmio_rd_addr);
      m_p_off     <= m_off(mmio_rd_addr);
      m_p_snap    <= m_ctrl[m_shim(mmio_rd_addr)];
      for (int s = 0; s < N; s++) begin
        if (mmio_wr_valid && m_hit(mmio_wr_addr) && m_shim(mmio_wr_addr) == s &&
            m_off(mmio_wr_addr) == 24) begin
          m_ctrl[s]  <= mmio_wr_data;
          m_pulse[s] <= 1'b1;
        end else begin
          m_ctrl[s]  <= m_ctrl[s] & ~SC;
          m_pulse[s] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rsp_valid", 64'(rd_rsp_valid), 64'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("rsp_tid", 64'(rd_rsp_tid), 64'(m_rsp_tid));
        chk("rsp_data", rd_rsp_data, m_rsp_data);
      end
      for (int s = 0; s < N; s++) begin
        chk($sformatf("ctrl_out[%0d]", s), ctrl_out[64*s +: 64], m_ctrl[s]);
        chk($sformatf("ctrl_wr_pulse[%0d]", s), 64'(ctrl_wr_pulse[s]), 64'(m_pulse[s]));
      end
    end
  end

  // Response log for the directed literal checks
  logic [8:0]  q_tid [$];
  logic [63:0] q_data [$];

  always @(negedge clk) begin
    if (rd_rsp_valid === 1'b1) begin
      q_tid.push_back(rd_rsp_tid);
      q_data.push_back(rd_rsp_data);
    end
  end

  task automatic expect_rsp(input string name, input logic [8:0] tid, input logic [63:0] data);
    if (q_tid.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response, required tid %h data %h", name, tid, data);
    end else begin
      chk({name, "_tid"}, 64'(q_tid.pop_front()), 64'(tid));
      chk({name, "_data"}, q_data.pop_front(), data);
    end
  endtask

  task automatic expect_none(input string name);
    chk(name, 64'(q_tid.size()), 64'd0);
  endtask

  task automatic qclear();
    q_tid.delete();
    q_data.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rv, input logic [15:0] ra, input logic [8:0] rt,
                     input bit wv, input logic [15:0] wa, input logic [63:0] wd);
    mmio_rd_valid = rv;
    mmio_rd_addr  = ra;
    mmio_rd_tid   = rt;
    mmio_wr_valid = wv;
    mmio_wr_addr  = wa;
    mmio_wr_data  = wd;
    @(posedge clk);
    #2;
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    if (rand_status) begin
      for (int j = 0; j < N * 2; j++) status_in[32*j +: 32] = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0, 9'h0, 1'b0, 16'h0, 64'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'(32'h406 + 32'h10 * $urandom_range(0, 2));
    return 16'(32'h3F0 + $urandom_range(0, 'h4F));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    mmio_rd_valid = 1'b0;
    mmio_rd_addr  = '0;
    mmio_rd_tid   = '0;
    mmio_wr_valid = 1'b0;
    mmio_wr_addr  = '0;
    mmio_wr_data  = '0;
    status_in     = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'hC0FF_EE00_1234_5678};

    // Reset for two cycles
    @(posedge clk); #2;
    cmp_en = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("reset_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    chk("reset_rsp_tid", 64'(rd_rsp_tid), 64'd0);
    chk("reset_rsp_data", rd_rsp_data, 64'd0);
    for (int s = 0; s < N; s++) chk($sformatf("reset_ctrl[%0d]", s), ctrl_out[64*s +: 64], 64'hA5);

    // DFH reads
    qclear();
    cyc(1'b1, 16'h410, 9'h2A, 1'b0, 16'h0, 64'h0);
    cyc(1'b1, 16'h420, 9'h2B, 1'b0, 16'h0, 64'h0);
    idle(4);
    expect_rsp("dfh1", 9'h2A, 64'h2000_0000_0040_0001);
    expect_rsp("dfh2", 9'h2B, 64'h2000_0100_0000_0002);
    expect_none("dfh_extra");

    // CTRL write with self-clearing bit
    cyc(1'b0, 16'h0, 9'h0, 1'b1, 16'h406, 64'h3);
    chk("ctrl_wr_value", ctrl_out[63:0], 64'h3);
    chk("ctrl_wr_pulse", 64'(ctrl_wr_pulse), 64'h1);
    idle(1);
    chk("ctrl_after_clear", ctrl_out[63:0], 64'h1);
    chk("ctrl_pulse_off", 64'(ctrl_wr_pulse), 64'h0);
    qclear();
    cyc(1'b1, 16'h406, 9'h03, 1'b0, 16'h0, 64'h0);
    idle(4);
    expect_rsp("ctrl_read", 9'h03, 64'h1);

    // Back-to-back reads
    qclear();
    cyc(1'b1, 16'h402, 9'h1, 1'b0, 16'h0, 64'h0);
    cyc(1'b1, 16'h404, 9'h2, 1'b0, 16'h0, 64'h0);
    cyc(1'b1, 16'h408, 9'h3, 1'b0, 16'h0, 64'h0);
    cyc(1'b1, 16'h412, 9'h4, 1'b0, 16'h0, 64'h0);
    idle(4);
    expect_rsp("guid_l0", 9'h1, 64'hFEDC_BA98_7654_3210);
    expect_rsp("guid_h0", 9'h2, 64'h0123_4567_89AB_CDEF);
    expect_rsp("status0", 9'h3, 64'hC0FF_EE00_1234_5678);
    expect_rsp("guid_l1", 9'h4, 64'h5555_6666_7777_8888);

    // Miss, unmapped offset, odd write
    qclear();
    cyc(1'b1, 16'h000, 9'h5, 1'b0, 16'h0, 64'h0);
    cyc(1'b1, 16'h40C, 9'h6, 1'b1, 16'h407, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("odd_wr_ctrl", ctrl_out[63:0], 64'h1);
    chk("odd_wr_pulse", 64'(ctrl_wr_pulse), 64'h0);
    idle(4);
    expect_rsp("unmapped", 9'h6, 64'h0);
    expect_none("miss_extra");

    // Same-cycle read and write of CTRL
    qclear();
    cyc(1'b1, 16'h406, 9'h7, 1'b1, 16'h406, 64'h5);
    idle(4);
    expect_rsp("rd_wr_same", 9'h7, 64'h1);

    // Reset the cycle after a read; a request during reset is ignored
    qclear();
    cyc(1'b1, 16'h410, 9'h9, 1'b0, 16'h0, 64'h0);
    reset = 1'b1;
    cyc(1'b1, 16'h412, 9'hA, 1'b1, 16'h406, 64'hFF);
    cyc(1'b0, 16'h0, 9'h0, 1'b0, 16'h0, 64'h0);
    reset = 1'b0;
    idle(4);
    expect_none("reset_drop");
    chk("reset_ctrl_again", ctrl_out[63:0], 64'hA5);

    // Randomized traffic against the model
    rand_status = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      cyc(1'($urandom_range(0, 1)), rand_addr(), 9'($urandom),
          1'($urandom_range(0, 2) == 0), rand_addr(), {$urandom, $urandom});
    end
    reset = 1'b0;
    idle(6);
    qclear();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
